// File: rtl/bram_wm_harness.sv
// bram_wm_harness: serial-command harness around a dual-port RAM with per-port write modes.
// The serial output port is named dout because "do" is a reserved word in SystemVerilog.
module bram_wm_harness #(
    parameter int    DATA_W       = 8,
    parameter int    ADDR_W       = 4,
    parameter string WRITE_MODE_A = "READ_FIRST",
    parameter string WRITE_MODE_B = "WRITE_FIRST",
    localparam int   CMD_N        = 2 * (2 + ADDR_W + DATA_W),
    localparam int   DOUT_N       = 2 * DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic di,
    output logic dout,
    output logic busy
);
    if (!(WRITE_MODE_A == "READ_FIRST" || WRITE_MODE_A == "WRITE_FIRST" || WRITE_MODE_A == "NO_CHANGE")) begin : g_bad_mode_a
        $error("bram_wm_harness: illegal WRITE_MODE_A");
    end
    if (!(WRITE_MODE_B == "READ_FIRST" || WRITE_MODE_B == "WRITE_FIRST" || WRITE_MODE_B == "NO_CHANGE")) begin : g_bad_mode_b
        $error("bram_wm_harness: illegal WRITE_MODE_B");
    end

    localparam bit A_WF = (WRITE_MODE_A == "WRITE_FIRST");
    localparam bit A_NC = (WRITE_MODE_A == "NO_CHANGE");
    localparam bit B_WF = (WRITE_MODE_B == "WRITE_FIRST");
    localparam bit B_NC = (WRITE_MODE_B == "NO_CHANGE");

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [CMD_N-1:0]    din_shr, cmd;
    logic [DOUT_N-1:0]   dout_shr;
    logic                cmd_vld, cap;
    logic [DATA_W-1:0]   dout_a, dout_b, a_nxt, b_nxt;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic                a_en, a_we, b_en, b_we;
    logic [ADDR_W-1:0]   a_addr, b_addr;
    logic [DATA_W-1:0]   a_data, b_data;

    assign {a_en, a_we, a_addr, a_data, b_en, b_we, b_addr, b_data} = cmd;
    assign busy = (state == CLEAR);
    assign cap  = stb && !busy;
    assign dout = dout_shr[DOUT_N-1];

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && ptr == '1) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) ptr <= ptr + 1'b1;
        end
    end

    // Reads see the pre-write contents, so cross-port collisions return old data.
    always_comb begin
        a_nxt = (a_we && A_WF) ? a_data : (a_we && A_NC) ? dout_a : mem[a_addr];
        b_nxt = (b_we && B_WF) ? b_data : (b_we && B_NC) ? dout_b : mem[b_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_shr  <= '0;
            cmd      <= '0;
            cmd_vld  <= 1'b0;
            dout_a   <= '0;
            dout_b   <= '0;
            dout_shr <= '0;
        end else begin
            din_shr  <= {din_shr[CMD_N-2:0], di};
            dout_shr <= cap ? {dout_a, dout_b} : {dout_shr[DOUT_N-2:0], din_shr[CMD_N-1]};
            cmd_vld  <= cap;
            if (cap) cmd <= din_shr;
            if (cmd_vld && a_en) dout_a <= a_nxt;
            if (cmd_vld && b_en) dout_b <= b_nxt;
        end
    end

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) mem[ptr] <= '0;
            else if (cmd_vld) begin
                if (a_en && a_we) mem[a_addr] <= a_data;
                if (b_en && b_we) mem[b_addr] <= b_data;
            end
        end
    end
endmodule

// File: tb/tb_bram_wm_harness.sv
// tb_bram_wm_harness: random and directed frames on two harness instances (RF/WF and NC/RF) against a reference model.
module tb_bram_wm_harness;
    logic clk = 1'b0, rst = 1'b1, stb = 1'b0, di = 1'b0;
    logic so_a, busy_a, so_b, busy_b;
    int   n_tests = 0, n_fail = 0;
    bit   hist[$];
    logic [7:0]  mem_m [2][16];
    logic [7:0]  da_m [2], db_m [2];
    logic [15:0] q0[$], q1[$];
    bit   skip;
    int   mode_a [2] = '{0, 2};
    int   mode_b [2] = '{1, 0};

    bram_wm_harness u_dut (.clk(clk), .rst(rst), .stb(stb), .di(di), .dout(so_a), .busy(busy_a));
    bram_wm_harness #(.WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST")) u_nc (
        .clk(clk), .rst(rst), .stb(stb), .di(di), .dout(so_b), .busy(busy_b));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic d, input logic s);
        di  = d;
        stb = s;
        @(posedge clk);
        if (!rst) hist.push_back(d);
        #1;
    endtask

    function automatic logic [27:0] mk(input logic aen, awe, input logic [3:0] aa, input logic [7:0] ad,
                                       input logic ben, bwe, input logic [3:0] ba, input logic [7:0] bd);
        return {aen, awe, aa, ad, ben, bwe, ba, bd};
    endfunction

    // mode: 0 read-first, 1 write-first, 2 no-change
    function automatic logic [7:0] port_out(input int mode, input logic en, we, input logic [7:0] oldv, data, hold);
        return !en ? hold : !we ? oldv : mode == 0 ? oldv : mode == 1 ? data : hold;
    endfunction

    task automatic model_step(input logic [27:0] c);
        logic aen, awe, ben, bwe;
        logic [3:0] aa, ba;
        logic [7:0] ad, bd;
        {aen, awe, aa, ad, ben, bwe, ba, bd} = c;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] oa, ob;
            oa = mem_m[k][aa];
            ob = mem_m[k][ba];
            da_m[k] = port_out(mode_a[k], aen, awe, oa, ad, da_m[k]);
            db_m[k] = port_out(mode_b[k], ben, bwe, ob, bd, db_m[k]);
            if (aen && awe) mem_m[k][aa] = ad;
            if (ben && bwe) mem_m[k][ba] = bd;
        end
        q0.push_back({da_m[0], db_m[0]});
        q1.push_back({da_m[1], db_m[1]});
    endtask

    task automatic frame(input logic [27:0] c);
        logic [15:0] o0 = '0, o1 = '0;
        for (int i = 0; i < 28; i++) begin
            if (i < 16) begin
                o0 = {o0[14:0], so_a};
                o1 = {o1[14:0], so_b};
            end
            cyc(c[27-i], 1'b0);
        end
        if (skip) skip = 1'b0;
        else begin
            chk("frame_rf_wf", o0, q0.pop_front());
            chk("frame_nc_rf", o1, q1.pop_front());
        end
        cyc(1'($urandom), 1'b1);
        model_step(c);
    endtask

    task automatic do_reset(input int abort_at);
        bit e_do;
        rst = 1'b1;
        stb = 1'b0;
        di  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a", busy_a, 1);
        chk("rst_busy_b", busy_b, 1);
        chk("rst_out_a", so_a, 0);
        chk("rst_out_b", so_b, 0);
        rst = 1'b0;
        hist.delete();
        if (abort_at > 0) begin
            repeat (abort_at) cyc(1'($urandom), 1'($urandom));
            chk("abort_busy", busy_a, 1);
            rst = 1'b1;
            cyc(1'b0, 1'b0);
            rst = 1'b0;
            hist.delete();
        end
        for (int e = 0; e < 70; e++) begin
            cyc(1'($urandom), (e < 16) && (e == 15 || 1'($urandom)));
            e_do = (hist.size() >= 44) ? hist[hist.size()-44] : 1'b0;
            chk("loop_a", so_a, e_do);
            chk("loop_b", so_b, e_do);
            chk("busy_a", busy_a, e < 15);
            chk("busy_b", busy_b, e < 15);
        end
        for (int k = 0; k < 2; k++) begin
            da_m[k] = '0;
            db_m[k] = '0;
            for (int j = 0; j < 16; j++) mem_m[k][j] = '0;
        end
        q0.delete();
        q1.delete();
        q0.push_back('0);
        q1.push_back('0);
        skip = 1'b1;
    endtask

    task automatic rand_frame();
        frame(mk(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom)));
    endtask

    initial begin
        do_reset(0);
        frame(mk(1, 0, 4'd5, 8'h00, 0, 0, 4'd0, 8'h00));
        frame(mk(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00));
        frame(mk(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00));
        frame(mk(0, 0, 4'd0, 8'h00, 1, 1, 4'd7, 8'h3C));
        frame(mk(1, 1, 4'd2, 8'h11, 1, 1, 4'd2, 8'h22));
        frame(mk(1, 0, 4'd2, 8'h00, 1, 0, 4'd2, 8'h00));
        frame(mk(1, 1, 4'd4, 8'h5A, 1, 0, 4'd4, 8'h00));
        frame(mk(1, 0, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00));
        frame(mk(1, 1, 4'd1, 8'hFF, 1, 0, 4'd1, 8'h00));
        frame(mk(1, 0, 4'd1, 8'h00, 1, 1, 4'd15, 8'hC3));
        frame(mk(1, 0, 4'd15, 8'h00, 1, 1, 4'd1, 8'h77));
        repeat (50) rand_frame();
        repeat (2) frame('0);
        do_reset(8);
        for (int j = 0; j < 16; j++) frame(mk(1, 0, 4'(j), 8'h00, 1, 0, 4'(15 - j), 8'h00));
        repeat (20) rand_frame();
        repeat (2) frame('0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_wm_harness.md
BRAM_WM_HARNESS -- requirements
Module: bram_wm_harness

Interface
REQ-001 Parameter DATA_W, default 8, data width of each RAM port.
REQ-002 Parameter ADDR_W, default 4, address width; RAM depth is 2**ADDR_W words.
REQ-003 Parameter WRITE_MODE_A, default "READ_FIRST", port A write mode: "READ_FIRST", "WRITE_FIRST" or "NO_CHANGE".
REQ-004 Parameter WRITE_MODE_B, default "WRITE_FIRST", port B write mode, same legal values as WRITE_MODE_A.
REQ-005 Any other mode string SHALL cause an elaboration error.
REQ-006 Derived widths: CMD_N = 2*(2+ADDR_W+DATA_W) and DOUT_N = 2*DATA_W.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port stb, input, 1 bit: frame strobe, latches the command and captures the outputs.
REQ-010 Port di, input, 1 bit: serial command input.
REQ-011 Port do, output, 1 bit: serial result output, equal to dout_shr[DOUT_N-1].
REQ-012 Port busy, output, 1 bit: high while the post-reset memory clear runs.

Function
REQ-013 Every cycle, din_shr SHALL update as din_shr <= {din_shr[CMD_N-2:0], di}.
REQ-014 On a cycle without capture, dout_shr SHALL update as dout_shr <= {dout_shr[DOUT_N-2:0], din_shr[CMD_N-1]} (loopback).
REQ-015 A capture happens when stb=1 and busy=0. On capture:
- cmd <= current din_shr;
- dout_shr <= {dout_a, dout_b};
- cmd_vld pulses high on the next cycle.
REQ-016 stb while busy=1 SHALL be ignored: no command latch, no capture, and shifting continues.
REQ-017 cmd field layout, MSB to LSB: a_en, a_we, a_addr[ADDR_W], a_data[DATA_W], b_en, b_we, b_addr, b_data.
REQ-018 On the cmd_vld cycle, each port SHALL execute once; dout_a and dout_b are registered and update at the end of that cycle.
REQ-019 Port behaviour on the cmd_vld cycle:
- en=0: dout holds.
- en=1, we=0: dout = mem[addr] (old contents).
REQ-020 Port behaviour for en=1, we=1; mem[addr] <= data in every mode:
- READ_FIRST: dout = old contents.
- WRITE_FIRST: dout = data.
- NO_CHANGE: dout holds.
REQ-021 Cross-port read during a write to the same address SHALL return the old contents, whatever the modes.
REQ-022 If both ports write the same address in the same cycle, port B data SHALL win.
REQ-023 Clear state machine, states IDLE and CLEAR.
- rst forces CLEAR with ptr=0.
- In CLEAR, each cycle writes mem[ptr] <= 0 and increments ptr.
- After ptr = 2**ADDR_W-1 is written, the FSM goes to IDLE.
REQ-024 busy = (state==CLEAR) and busy is registered.
- busy is high for exactly 2**ADDR_W cycles after rst deasserts.
- No port operations execute while busy.
REQ-025 Latency: the result of a frame captured at stb edge t is available in dout_shr at the next capture, after at least 2 cycles.
- do shifts out the dout_a MSB first, then dout_b.

Reset
REQ-026 While rst=1, din_shr, cmd, cmd_vld, dout_a, dout_b and dout_shr SHALL be held at 0; state=CLEAR, ptr=0, busy=1.
REQ-027 Asserting rst mid-clear or mid-frame SHALL abort the operation and restart the clear from address 0; a pending cmd_vld is dropped.
REQ-028 Memory contents SHALL be defined only by the clear sequence, never by initial values.

Verification (DATA_W=8, ADDR_W=4, CMD_N=28, DOUT_N=16)
REQ-029 Release rst -> busy=1 for exactly 16 cycles, then 0; a port A read of addr 5 then returns dout_a=0x00.
REQ-030 Port A write addr 3 data 0xA5 (READ_FIRST) -> dout_a=0x00; a following A read of addr 3 -> 0xA5, shifted out MSB first on do.
REQ-031 Port B write addr 7 data 0x3C (WRITE_FIRST) -> dout_b=0x3C in the same cmd_vld cycle.
REQ-032 A writes addr 2 data 0x11 and B writes addr 2 data 0x22 in one frame -> a subsequent read of addr 2 returns 0x22.
REQ-033 WRITE_MODE_A="NO_CHANGE", dout_a=0x5A, then A writes addr 1 data 0xFF -> dout_a stays 0x5A; an A read of addr 1 -> 0xFF.
REQ-034 Assert rst for 1 cycle at clear cycle 8 -> busy stays high for 16 further cycles, and stb pulsed during busy is ignored (dout_shr keeps shifting).
